rvv_rt_trace_collector: RTL

//  Captures retire events from NUM_RT parallel ROB->retire lanes into a trace FIFO.

---
 rtl/rvv_rt_trace_collector.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/rvv_rt_trace_collector.sv
// rvv_rt_trace_collector: packs the fired retire lanes of each cycle into a trace FIFO that drains one entry per cycle.
// Optional feature macro RVV_RT_TRACE_VXSAT_EN adds a per-entry vxsat bit (MSB of trc_data) and a sticky vxsat_seen flag.
module rvv_rt_trace_collector #(
  parameter int NUM_RT = 4,
  parameter int DEPTH  = 16,
  parameter int PC_W   = 32,
  parameter int IDX_W  = 5,
  parameter int VLENB  = 16,
  parameter int CNT_W  = 32,
`ifdef RVV_RT_TRACE_VXSAT_EN
  localparam int VX_W  = 1,
`else
  localparam int VX_W  = 0,
`endif
  localparam int LANE_W = (NUM_RT > 1) ? $clog2(NUM_RT) : 1,
  localparam int ENT_W  = VX_W + LANE_W + 1 + IDX_W + VLENB + PC_W,
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [NUM_RT-1:0]         rt_valid,
  input  logic [NUM_RT-1:0]         rt_ready,
  input  logic [NUM_RT-1:0]         rt_last,
  input  logic [NUM_RT*PC_W-1:0]    rt_pc,
  input  logic [NUM_RT*IDX_W-1:0]   rt_index,
  input  logic [NUM_RT*VLENB-1:0]   rt_strobe,
  input  logic [NUM_RT-1:0]         rt_vxsat,
  output logic                      trc_valid,
  input  logic                      trc_ready,
  output logic [ENT_W-1:0]          trc_data,
  output logic [LVL_W-1:0]          trc_level,
  output logic [CNT_W-1:0]          inst_cnt,
  output logic [CNT_W-1:0]          drop_cnt,
  output logic [NUM_RT-1:0]         rt_fire_d1,
  output logic                      vxsat_seen
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ENT_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic [CNT_W-1:0]  r_inst_cnt;
  logic [CNT_W-1:0]  r_drop_cnt;
  logic [NUM_RT-1:0] r_fire_d1;

  logic [NUM_RT-1:0] w_fire;
  logic [NUM_RT-1:0] w_store;
  logic [PTR_W-1:0]  w_addr [NUM_RT];
  logic [ENT_W-1:0]  w_ent  [NUM_RT];
  logic [LVL_W-1:0]  w_k;
  logic [LVL_W-1:0]  w_free;
  logic [LVL_W-1:0]  w_stored;
  logic [LVL_W-1:0]  w_drop;
  logic [CNT_W-1:0]  w_inst_inc;
  logic [CNT_W:0]    w_drop_sum;
  logic              w_pop;

  // Each fired lane takes the slot after the fired lanes below it; only the first 'free' ranks fit.
  always_comb begin
    w_fire     = rt_valid & rt_ready;
    w_free     = LVL_W'(DEPTH) - r_level;
    w_k        = '0;
    w_inst_inc = '0;
    for (int i = 0; i < NUM_RT; i++) begin
      w_store[i] = w_fire[i] && (w_k < w_free) && !flush;
      w_addr[i]  = r_wr_ptr + w_k[PTR_W-1:0];
`ifdef RVV_RT_TRACE_VXSAT_EN
      w_ent[i]   = {rt_vxsat[i], LANE_W'(i), rt_last[i], rt_index[i*IDX_W +: IDX_W],
                    rt_strobe[i*VLENB +: VLENB], rt_pc[i*PC_W +: PC_W]};
`else
      w_ent[i]   = {LANE_W'(i), rt_last[i], rt_index[i*IDX_W +: IDX_W],
                    rt_strobe[i*VLENB +: VLENB], rt_pc[i*PC_W +: PC_W]};
`endif
      w_k        = w_k + LVL_W'(w_fire[i]);
      w_inst_inc = w_inst_inc + CNT_W'(w_fire[i] & rt_last[i]);
    end
    w_stored   = (w_k < w_free) ? w_k : w_free;
    w_drop     = flush ? '0 : (w_k - w_stored);
    w_drop_sum = {1'b0, r_drop_cnt} + (CNT_W+1)'(w_drop);
  end

  assign trc_valid = (r_level != '0);
  assign w_pop     = trc_valid & trc_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_inst_cnt <= '0;
      r_drop_cnt <= '0;
      r_fire_d1  <= '0;
    end else begin
      r_fire_d1  <= w_fire;
      r_inst_cnt <= r_inst_cnt + w_inst_inc;
      if (flush) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_level    <= '0;
        r_drop_cnt <= '0;
      end else begin
        r_wr_ptr <= r_wr_ptr + w_stored[PTR_W-1:0];
        if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_level  <= r_level + w_stored - LVL_W'(w_pop);
        r_drop_cnt <= w_drop_sum[CNT_W] ? '1 : w_drop_sum[CNT_W-1:0];
      end
    end
  end

  // Storage carries no reset; an empty FIFO masks the head to zero instead.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_RT; i++) begin
      if (w_store[i]) r_mem[w_addr[i]] <= w_ent[i];
    end
  end

  assign trc_data   = trc_valid ? r_mem[r_rd_ptr] : '0;
  assign trc_level  = r_level;
  assign inst_cnt   = r_inst_cnt;
  assign drop_cnt   = r_drop_cnt;
  assign rt_fire_d1 = r_fire_d1;

`ifdef RVV_RT_TRACE_VXSAT_EN
  logic r_vxsat_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_vxsat_seen <= 1'b0;
    else if (|(w_fire & rt_vxsat)) r_vxsat_seen <= 1'b1;
  end

  assign vxsat_seen = r_vxsat_seen;
`else
  // rt_vxsat is observed but has no effect without the feature.
  assign vxsat_seen = 1'b0 & (|rt_vxsat);
`endif

endmodule
